// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
//   Command-driven AXI4-Lite master. A local requester pulses `transfer` while
//   `ready` is high; the master runs one AXI4-Lite read or write transaction
//   and reports completion with a one-cycle `done` strobe, the response code
//   on `resp` and, for reads, the returned data on `rdata`. One outstanding
//   transaction at a time. Every output comes straight from a flop.
//
//   Optional build macro:
//     AXIM_TIMEOUT_EN - abort a stalled transaction after TIMEOUT_CYCLES busy
//                       cycles with a local SLVERR (resp = 2'b10).
//
//   Ports
//     ACLK, ARESET        clock, asynchronous active-high reset
//     transfer/write/addr/wdata   command, sampled while ready = 1
//     ready, done, resp, rdata    requester status / results
//     AW*, W*, B*, AR*, R*        AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axi_lite_master #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              transfer,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [1:0]        resp,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [1:0]        RRESP
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R
  } state_e;

  state_e              state_q,   state_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
  logic [1:0]          resp_q,    resp_d;
  logic                ready_q,   ready_d;
  logic                done_q,    done_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q,  wvalid_d;
  logic                bready_q,  bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q,  rready_d;
  logic                aw_acc_q,  aw_acc_d;
  logic                w_acc_q,   w_acc_d;
  logic                aw_hs;
  logic                w_hs;

`ifdef AXIM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // Last count value before the abort fires: after TIMEOUT_CYCLES busy cycles.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  assign ready   = ready_q;
  assign done    = done_q;
  assign resp    = resp_q;
  assign rdata   = rdata_q;
  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;
  assign WDATA   = wdata_q;
  assign AWVALID = awvalid_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

  assign aw_hs = awvalid_q & AWREADY;
  assign w_hs  = wvalid_q & WREADY;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    aw_acc_d  = aw_acc_q;
    w_acc_d   = w_acc_q;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          addr_d  = addr;
          wdata_d = wdata;
          ready_d = 1'b0;
          if (write) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_acc_d  = 1'b0;
            w_acc_d   = 1'b0;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end

      WR_AW_W: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_acc_d  = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_acc_d  = 1'b1;
        end
        // Either channel may finish first, or both in the same cycle.
        if ((aw_acc_q | aw_hs) & (w_acc_q | w_hs)) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end

      WR_B: begin
        if (BVALID) begin
          resp_d   = BRESP;
          done_d   = 1'b1;
          ready_d  = 1'b1;
          bready_d = 1'b0;
          state_d  = IDLE;
        end
      end

      RD_AR: begin
        if (arvalid_q & ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end

      RD_R: begin
        if (RVALID) begin
          rdata_d  = RDATA;
          resp_d   = RRESP;
          done_d   = 1'b1;
          ready_d  = 1'b1;
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase

`ifdef AXIM_TIMEOUT_EN
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (transfer) begin
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      // A state-advancing handshake in the expiry cycle takes precedence.
      if ((cnt_q >= TO_LAST) && (state_d == state_q)) begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        ready_d   = 1'b1;
        done_d    = 1'b1;
        resp_d    = 2'b10;
      end
    end
`endif
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_acc_q  <= 1'b0;
      w_acc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      aw_acc_q  <= aw_acc_d;
      w_acc_q   <= w_acc_d;
    end
  end

`ifdef AXIM_TIMEOUT_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
//   Directed plus randomized bench for axi_lite_master. A behavioural
//   4-register AXI4-Lite slave with programmable per-channel wait states
//   answers the master; a word-array reference model predicts resp/rdata and
//   the accept-to-done latency of each command.
// -----------------------------------------------------------------------------
module tb_axi_lite_master;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int TO_CYC = 255;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic              transfer = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              ready, done;
  logic [1:0]        resp;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic              AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [DATA_W-1:0] WDATA;
  logic              AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic              ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]        BRESP = '0, RRESP = '0;
  logic [DATA_W-1:0] RDATA = '0;

  axi_lite_master #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .ready   (ready),
    .done    (done),
    .resp    (resp),
    .rdata   (rdata),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .RRESP   (RRESP)
  );

  always #5 ACLK = ~ACLK;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned done_pulses = 0;
  int unsigned exp_done_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int unsigned aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit          b_never = 1'b0;
  bit          slave_flush = 1'b0;
  logic [1:0]  next_bresp = '0, next_rresp = '0;
  logic [31:0] slave_mem [4] = '{default: '0};
  logic [3:0]  s_awaddr = '0, s_araddr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  last_awaddr = '0;
  logic [31:0] last_wdata = '0;
  bit          aw_seen = 0, w_seen = 0, ar_seen = 0;
  bit          aw_hs_e = 0, w_hs_e = 0, b_hs_e = 0, ar_hs_e = 0, r_hs_e = 0;
  bit          aw_v_e = 0, w_v_e = 0, ar_v_e = 0;

  // current command, used for stability checks
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  bit          cmd_write = 0;
  logic [1:0]  cmd_resp = '0;

  always @(posedge ACLK) begin
    aw_hs_e = AWVALID & AWREADY;
    w_hs_e  = WVALID & WREADY;
    b_hs_e  = BVALID & BREADY;
    ar_hs_e = ARVALID & ARREADY;
    r_hs_e  = RVALID & RREADY;
    aw_v_e  = AWVALID;
    w_v_e   = WVALID;
    ar_v_e  = ARVALID;
  end

  always @(negedge ACLK) begin
    if (done === 1'b1) done_pulses++;
    if (ARESET || slave_flush) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (AWVALID === 1'b1) chk("awaddr_stable", 32'(AWADDR), 32'(cmd_addr));
      if (WVALID === 1'b1)  chk("wdata_stable", WDATA, cmd_wdata);
      if (ARVALID === 1'b1) chk("araddr_stable", 32'(ARADDR), 32'(cmd_addr));
      if (aw_v_e && !aw_hs_e) chk("awvalid_held", 32'(AWVALID), 32'd1);
      if (w_v_e && !w_hs_e)   chk("wvalid_held", 32'(WVALID), 32'd1);
      if (ar_v_e && !ar_hs_e) chk("arvalid_held", 32'(ARVALID), 32'd1);

      if (AWREADY) begin
        if (aw_hs_e) begin AWREADY = 0; aw_seen = 1; end
      end else if (AWVALID === 1'b1) begin
        if (aw_cnt >= aw_dly) begin AWREADY = 1; s_awaddr = AWADDR; aw_cnt = 0; end
        else aw_cnt++;
      end

      if (WREADY) begin
        if (w_hs_e) begin WREADY = 0; w_seen = 1; end
      end else if (WVALID === 1'b1) begin
        if (w_cnt >= w_dly) begin WREADY = 1; s_wdata = WDATA; w_cnt = 0; end
        else w_cnt++;
      end

      if (BVALID) begin
        if (b_hs_e) BVALID = 0;
      end else if (aw_seen && w_seen && !b_never) begin
        if (b_cnt >= b_dly) begin
          BVALID = 1; BRESP = next_bresp;
          slave_mem[s_awaddr[3:2]] = s_wdata;
          last_awaddr = s_awaddr; last_wdata = s_wdata;
          aw_seen = 0; w_seen = 0; b_cnt = 0;
        end else b_cnt++;
      end

      if (ARREADY) begin
        if (ar_hs_e) begin ARREADY = 0; ar_seen = 1; end
      end else if (ARVALID === 1'b1) begin
        if (ar_cnt >= ar_dly) begin ARREADY = 1; s_araddr = ARADDR; ar_cnt = 0; end
        else ar_cnt++;
      end

      if (RVALID) begin
        if (r_hs_e) RVALID = 0;
      end else if (ar_seen) begin
        if (r_cnt >= r_dly) begin
          RVALID = 1; RDATA = slave_mem[s_araddr[3:2]]; RRESP = next_rresp;
          ar_seen = 0; r_cnt = 0;
        end else r_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [4] = '{default: '0};
  logic [31:0] exp_rdata = '0;

  // Called just after a negedge while the master is idle.
  task automatic issue(input bit w, input logic [3:0] a, input logic [31:0] d, input logic [1:0] r);
    chk("ready_before_cmd", 32'(ready), 32'd1);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_resp = r;
    next_bresp = r; next_rresp = r;
    transfer = 1; write = w; addr = a; wdata = d;
    @(posedge ACLK);
    #1;
    transfer = 0;
    addr = 4'($urandom);
    wdata = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input bit poke, input bit timeout_exp);
    bit got = 0;
    int k = 0;
    while (!got && k < 400) begin
      @(negedge ACLK);
      k++;
      if (poke && k == 2) begin
        chk("ready_busy", 32'(ready), 32'd0);
        transfer = 1; write = 1'($urandom_range(0, 1)); addr = 4'($urandom); wdata = $urandom;
      end
      if (poke && k == 3) transfer = 0;
      if (done === 1'b1) got = 1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(k), 32'(exp_lat));
    if (got) begin
      exp_done_pulses++;
      if (timeout_exp) begin
        chk("resp_timeout", 32'(resp), 32'h2);
      end else if (cmd_write) begin
        ref_mem[cmd_addr[3:2]] = cmd_wdata;
        chk("bresp", 32'(resp), 32'(cmd_resp));
        chk("slave_awaddr", 32'(last_awaddr), 32'(cmd_addr));
        chk("slave_wdata", last_wdata, cmd_wdata);
      end else begin
        exp_rdata = ref_mem[cmd_addr[3:2]];
        chk("rresp", 32'(resp), 32'(cmd_resp));
      end
      chk("rdata", rdata, exp_rdata);
      chk("ready_at_done", 32'(ready), 32'd1);
      chk("chan_idle_at_done", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    repeat (3) @(negedge ACLK);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_chan", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'd0);
    chk("rst_addr", 32'({AWADDR, ARADDR}), 32'd0);
    chk("rst_wdata", WDATA, 32'd0);
    #1 ARESET = 0;
    @(negedge ACLK);

    // zero-wait write then read back
    issue(1, 4'h4, 32'hDEADBEEF, 2'b00);
    wait_done(3, 0, 0);
    @(negedge ACLK);
    chk("done_one_cycle_w", 32'(done), 32'd0);
    issue(0, 4'h4, 32'h0, 2'b00);
    wait_done(3, 0, 0);
    chk("rdata_deadbeef", rdata, 32'hDEADBEEF);
    @(negedge ACLK);
    chk("done_one_cycle_r", 32'(done), 32'd0);

    // W accepted four cycles before AW; rdata must survive the write
    aw_dly = 4; w_dly = 0;
    issue(1, 4'h8, 32'hA5A5_0F0F, 2'b01);
    wait_done(7, 0, 0);
    aw_dly = 0;

    // transfer while busy is ignored; transfer in done cycle is accepted
    aw_dly = 2; w_dly = 1;
    issue(1, 4'hC, 32'h1357_9BDF, 2'b00);
    wait_done(5, 1, 0);
    aw_dly = 0; w_dly = 0;
    issue(0, 4'h8, 32'h0, 2'b11);
    wait_done(3, 0, 0);
    issue(0, 4'hC, 32'h0, 2'b00);
    wait_done(3, 0, 0);
    @(negedge ACLK);

    // reset while waiting for B
    b_dly = 40;
    issue(1, 4'h0, 32'h1234_5678, 2'b00);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge ACLK);
      if (BREADY === 1'b1) seen = 1;
    end
    chk("reached_wr_b", 32'(seen), 32'd1);
    #1 ARESET = 1;
    #1;
    chk("async_rst_chan", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd1);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_rdata", rdata, 32'd0);
    exp_rdata = '0;
    @(negedge ACLK);
    #1 ARESET = 0;
    b_dly = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("no_done_after_rst", 32'(done), 32'd0);
    end
    issue(0, 4'h0, 32'h0, 2'b00);
    wait_done(3, 0, 0);

`ifdef AXIM_TIMEOUT_EN
    b_never = 1;
    issue(1, 4'h4, 32'hCAFE_F00D, 2'b00);
    wait_done(TO_CYC + 1, 0, 1);
    chk("bready_after_timeout", 32'(BREADY), 32'd0);
    slave_flush = 1;
    b_never = 0;
    @(negedge ACLK);
    #1 slave_flush = 0;
    issue(0, 4'h4, 32'h0, 2'b00);
    wait_done(3, 0, 0);
`endif

    // randomized traffic with random wait states and responses
    for (int t = 0; t < 24; t++) begin
      bit          w;
      logic [3:0]  a;
      logic [31:0] d;
      logic [1:0]  r;
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom);
      d = $urandom;
      r = 2'($urandom);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      if (w) lat = 3 + int'((aw_dly > w_dly) ? aw_dly : w_dly) + int'(b_dly);
      else   lat = 3 + int'(ar_dly) + int'(r_dly);
      issue(w, a, d, r);
      wait_done(lat, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end

    @(negedge ACLK);
    chk("done_pulse_count", done_pulses, exp_done_pulses);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
